// File: rtl/spi_flash_reader.sv
// -----------------------------------------------------------------------------
// spi_flash_reader
//
// Command sequencer that sits directly above a byte-wide SPI engine. A single
// request reads req_len 32-bit words starting at flash byte address req_addr:
// chip select is dropped, the read opcode and three address bytes are sent,
// then 4*req_len bytes are clocked in and packed big-endian into words that
// leave on a valid/ready stream. The flash auto-increments its address, so the
// address is sent once per request.
//
// Build option:
//   SPI_FLASH_FASTREAD_EN  - when defined, the fast-read opcode 8'h0B is used
//                            and one dummy byte follows the address. The byte
//                            received during the dummy slot is dropped. When
//                            undefined, READ_OPCODE is used with no dummy byte.
//
// Parameters:
//   CS_GUARD_CLKS - clk cycles cs_n is low before the first start, low after
//                   the last done, and high between requests (must be >= 1)
//   READ_OPCODE   - opcode for normal read mode
//
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   req_valid/req_ready, req_addr[23:0], req_len[7:0]
//                 - read request handshake; req_len = 0 is accepted as a no-op
//   word_valid/word_ready, word_data[31:0]
//                 - output word stream; first received byte lands in [31:24]
//   busy          - high from request accept until return to idle
//   spi_in_byte[7:0], spi_start
//                 - byte to send and one-cycle start pulse to the engine
//   spi_out_byte[7:0], spi_done
//                 - received byte and one-cycle completion pulse from the engine
//   cs_n          - flash chip select, active low
// -----------------------------------------------------------------------------
module spi_flash_reader #(
  parameter int unsigned CS_GUARD_CLKS = 2,
  parameter logic [7:0]  READ_OPCODE   = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic        busy,
  output logic [7:0]  spi_in_byte,
  output logic        spi_start,
  input  logic [7:0]  spi_out_byte,
  input  logic        spi_done,
  output logic        cs_n
);

  // Guard counters run 0 .. CS_GUARD_CLKS-1.
  localparam logic [7:0] GUARD_LAST = 8'(CS_GUARD_CLKS - 1);

`ifdef SPI_FLASH_FASTREAD_EN
  localparam logic [7:0] CMD_OPCODE = 8'h0B;
`else
  localparam logic [7:0] CMD_OPCODE = READ_OPCODE;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_CS_SETUP,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_HOLD,
    S_CS_HOLD_LO,
    S_CS_HOLD_HI
  } state_e;

  state_e      state_q;
  logic [23:0] addr_q;        // shifted left one byte per address byte sent
  logic [7:0]  rem_q;         // words still to deliver
  logic [7:0]  guard_q;       // chip-select guard counter
  logic [1:0]  idx_q;         // address byte index or data byte lane
  logic [23:0] shift_q;       // bytes of the word received so far
  logic        wait_q;        // a byte is outstanding at the engine
  logic        req_ready_q;
  logic        word_valid_q;
  logic [31:0] word_data_q;
  logic        busy_q;
  logic [7:0]  spi_in_byte_q;
  logic        spi_start_q;
  logic        cs_n_q;

  // Word as it looks once the current engine byte is appended.
  logic [31:0] word_d;
  // Completion pulse that belongs to the outstanding byte. A done during the
  // start cycle itself or with nothing outstanding is stray and ignored.
  logic        done_d;

  always_comb begin
    word_d = {shift_q, spi_out_byte};
    done_d = spi_done & wait_q & ~spi_start_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only, so it lives inside the
    // clocked branch rather than in the sensitivity list.
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      guard_q       <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      wait_q        <= 1'b0;
      req_ready_q   <= 1'b0;
      word_valid_q  <= 1'b0;
      word_data_q   <= '0;
      busy_q        <= 1'b0;
      spi_in_byte_q <= '0;
      spi_start_q   <= 1'b0;
      cs_n_q        <= 1'b1;
    end else begin
      // NOTE: the start strobe defaults low every cycle and is raised only by
      // the branch that issues a byte, which makes it a one-cycle pulse.
      spi_start_q <= 1'b0;
      if (done_d) begin
        wait_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            addr_q <= req_addr;
            rem_q  <= req_len;
            // A zero-length request is consumed without touching the flash.
            if (req_len != 8'd0) begin
              req_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              cs_n_q      <= 1'b0;
              guard_q     <= '0;
              state_q     <= S_CS_SETUP;
            end
          end
        end

        S_CS_SETUP: begin
          // cs_n fell on entry; the opcode start lands CS_GUARD_CLKS later.
          if (guard_q == GUARD_LAST) begin
            spi_in_byte_q <= CMD_OPCODE;
            spi_start_q   <= 1'b1;
            wait_q        <= 1'b1;
            state_q       <= S_CMD;
          end else begin
            guard_q <= guard_q + 8'd1;
          end
        end

        S_CMD: begin
          if (done_d) begin
            spi_in_byte_q <= addr_q[23:16];
            addr_q        <= {addr_q[15:0], 8'h00};
            spi_start_q   <= 1'b1;
            wait_q        <= 1'b1;
            idx_q         <= 2'd0;
            state_q       <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (done_d) begin
            spi_in_byte_q <= 8'h00;
            spi_start_q   <= 1'b1;
            wait_q        <= 1'b1;
            if (idx_q == 2'd2) begin
              idx_q <= 2'd0;
`ifdef SPI_FLASH_FASTREAD_EN
              state_q <= S_DUMMY;
`else
              state_q <= S_DATA;
`endif
            end else begin
              spi_in_byte_q <= addr_q[23:16];
              addr_q        <= {addr_q[15:0], 8'h00};
              idx_q         <= idx_q + 2'd1;
            end
          end
        end

        S_DUMMY: begin
          // The byte clocked in during the dummy slot carries no data.
          if (done_d) begin
            spi_in_byte_q <= 8'h00;
            spi_start_q   <= 1'b1;
            wait_q        <= 1'b1;
            idx_q         <= 2'd0;
            state_q       <= S_DATA;
          end
        end

        S_DATA: begin
          if (done_d) begin
            shift_q <= word_d[23:0];
            if (idx_q == 2'd3) begin
              word_data_q  <= word_d;
              word_valid_q <= 1'b1;
              state_q      <= S_HOLD;
            end else begin
              spi_in_byte_q <= 8'h00;
              spi_start_q   <= 1'b1;
              wait_q        <= 1'b1;
              idx_q         <= idx_q + 2'd1;
            end
          end
        end

        S_HOLD: begin
          // No byte is started while the word waits, so the SPI clock simply
          // pauses with cs_n still low.
          if (word_ready) begin
            word_valid_q <= 1'b0;
            rem_q        <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              guard_q <= '0;
              state_q <= S_CS_HOLD_LO;
            end else begin
              spi_in_byte_q <= 8'h00;
              spi_start_q   <= 1'b1;
              wait_q        <= 1'b1;
              idx_q         <= 2'd0;
              state_q       <= S_DATA;
            end
          end
        end

        S_CS_HOLD_LO: begin
          if (guard_q == GUARD_LAST) begin
            cs_n_q  <= 1'b1;
            guard_q <= '0;
            state_q <= S_CS_HOLD_HI;
          end else begin
            guard_q <= guard_q + 8'd1;
          end
        end

        S_CS_HOLD_HI: begin
          // Minimum deselect time before the next request can be taken.
          if (guard_q == GUARD_LAST) begin
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            guard_q <= guard_q + 8'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign word_valid  = word_valid_q;
  assign word_data   = word_data_q;
  assign busy        = busy_q;
  assign spi_in_byte = spi_in_byte_q;
  assign spi_start   = spi_start_q;
  assign cs_n        = cs_n_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_reader
//
// Bench for spi_flash_reader. A behavioural SPI engine plus flash answers each
// start with a done two cycles later; header bytes answer 8'hFF and data bytes
// come from a response queue. Expected transmitted bytes and expected words are
// queued when a request is planned and compared as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_spi_flash_reader;

  localparam int GUARD = 2;
`ifdef SPI_FLASH_FASTREAD_EN
  localparam logic [7:0] OPC = 8'h0B;
  localparam int         HDR = 5;
`else
  localparam logic [7:0] OPC = 8'h03;
  localparam int         HDR = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic [31:0] word_data;
  logic        busy;
  logic [7:0]  spi_in_byte;
  logic        spi_start;
  logic [7:0]  spi_out_byte = '0;
  logic        spi_done = 1'b0;
  logic        cs_n;

  spi_flash_reader #(
    .CS_GUARD_CLKS(GUARD),
    .READ_OPCODE  (8'h03)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .busy        (busy),
    .spi_in_byte (spi_in_byte),
    .spi_start   (spi_start),
    .spi_out_byte(spi_out_byte),
    .spi_done    (spi_done),
    .cs_n        (cs_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues.
  logic [7:0]  exp_tx_q[$];
  logic [31:0] exp_word_q[$];
  logic [7:0]  resp_q[$];

  // Engine/flash model and monitor state.
  int   cyc = 0;
  int   lat = 0;
  int   nbytes = 0;
  int   pend_idx = 0;
  int   ndone = 0;
  int   starts = 0;
  int   words_seen = 0;
  int   rises = 0;
  int   fall_cyc = -100;
  int   rise_cyc = -100;
  int   last_done_cyc = -100;
  bit   first_pending = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_wv = 1'b0;
  logic prev_acc = 1'b0;
  logic [31:0] prev_data = '0;

  // Advance one clock: at the falling edge run the engine model and the
  // scoreboard, then return 1 time unit after the next rising edge, which is
  // where all stimulus changes.
  task automatic step();
    logic [7:0] e;
    logic [31:0] ew;
    @(negedge clk);
    cyc++;
    if (reset) begin
      exp_tx_q.delete();
      exp_word_q.delete();
      resp_q.delete();
      spi_done = 1'b0;
      lat = 0;
      nbytes = 0;
      first_pending = 1'b0;
      if (!prev_cs && cs_n) begin
        rise_cyc = cyc;
        rises++;
      end
      prev_cs = cs_n;
      prev_wv = 1'b0;
      prev_acc = 1'b0;
    end else begin
      // Engine model.
      spi_done = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          spi_done = 1'b1;
          ndone++;
          last_done_cyc = cyc;
          if (pend_idx < HDR) spi_out_byte = 8'hFF;
          else if (resp_q.size() > 0) spi_out_byte = resp_q.pop_front();
          else spi_out_byte = 8'h5A;
        end
      end
      if (cs_n) nbytes = 0;
      if (spi_start) begin
        starts++;
        checks++;
        if (lat != 0) begin
          errors++;
          $display("FAIL overlap_start: start with byte outstanding, lat=%0d want 0", lat);
        end
        pend_idx = nbytes;
        nbytes++;
        lat = 2;
      end

      // Chip-select timing.
      if (prev_cs && !cs_n) begin
        checks++;
        if (cyc - rise_cyc < GUARD) begin
          errors++;
          $display("FAIL cs_high_gap: got %0d cycles high, want >= %0d", cyc - rise_cyc, GUARD);
        end
        fall_cyc = cyc;
        first_pending = 1'b1;
      end
      if (!prev_cs && cs_n) begin
        checks++;
        if (cyc - last_done_cyc < GUARD) begin
          errors++;
          $display("FAIL cs_rise_gap: got %0d cycles after done, want >= %0d", cyc - last_done_cyc, GUARD);
        end
        rise_cyc = cyc;
        rises++;
      end

      // Transmitted bytes.
      if (spi_start) begin
        if (first_pending) begin
          checks++;
          if (cyc - fall_cyc != GUARD) begin
            errors++;
            $display("FAIL cs_setup: got %0d cycles fall-to-start, want %0d", cyc - fall_cyc, GUARD);
          end
          first_pending = 1'b0;
        end
        checks++;
        if (exp_tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_byte: unexpected start with byte %02h, want none", spi_in_byte);
        end else begin
          e = exp_tx_q.pop_front();
          if (spi_in_byte !== e) begin
            errors++;
            $display("FAIL tx_byte: got %02h want %02h", spi_in_byte, e);
          end
        end
        checks++;
        if (word_valid !== 1'b0 || cs_n !== 1'b0) begin
          errors++;
          $display("FAIL start_cond: word_valid=%b cs_n=%b at start, want 0 0", word_valid, cs_n);
        end
      end

      // Output word stream.
      if (word_valid && prev_wv && !prev_acc) begin
        checks++;
        if (word_data !== prev_data) begin
          errors++;
          $display("FAIL word_hold: got %08h want %08h", word_data, prev_data);
        end
      end
      if (word_valid && word_ready) begin
        words_seen++;
        checks++;
        if (exp_word_q.size() == 0) begin
          errors++;
          $display("FAIL word_data: unexpected word %08h, want none", word_data);
        end else begin
          ew = exp_word_q.pop_front();
          if (word_data !== ew) begin
            errors++;
            $display("FAIL word_data: got %08h want %08h", word_data, ew);
          end
        end
      end
      prev_wv = word_valid;
      prev_acc = word_valid & word_ready;
      prev_data = word_data;
      prev_cs = cs_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic plan_hdr(input logic [23:0] a, input logic [7:0] n);
    exp_tx_q.push_back(OPC);
    exp_tx_q.push_back(a[23:16]);
    exp_tx_q.push_back(a[15:8]);
    exp_tx_q.push_back(a[7:0]);
`ifdef SPI_FLASH_FASTREAD_EN
    exp_tx_q.push_back(8'h00);
`endif
    for (int i = 0; i < 4 * int'(n); i++) exp_tx_q.push_back(8'h00);
  endtask

  task automatic plan_word(input logic [31:0] w);
    exp_word_q.push_back(w);
    resp_q.push_back(w[31:24]);
    resp_q.push_back(w[23:16]);
    resp_q.push_back(w[15:8]);
    resp_q.push_back(w[7:0]);
  endtask

  task automatic send_req(input logic [23:0] a, input logic [7:0] n, output bit ok);
    ok = 1'b0;
    req_addr = a;
    req_len = n;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_accept: req_ready not seen in 50 cycles, want 1");
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done_ok;
    done_ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (busy === 1'b0 && cs_n === 1'b1 && req_ready === 1'b1 &&
          exp_tx_q.size() == 0 && exp_word_q.size() == 0) begin
        done_ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!done_ok) begin
      errors++;
      $display("FAIL %s_idle: timeout busy=%b cs_n=%b tx_left=%0d words_left=%0d, want idle",
               tag, busy, cs_n, exp_tx_q.size(), exp_word_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({req_ready, word_valid, busy, spi_start, cs_n} !== 5'b00001 ||
        word_data !== 32'h0 || spi_in_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_vals: got rr=%b wv=%b busy=%b st=%b cs=%b wd=%08h ib=%02h, want 0 0 0 0 1 0 0",
               req_ready, word_valid, busy, spi_start, cs_n, word_data, spi_in_byte);
    end
    reset = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    int w0;
    w0 = words_seen;
    plan_hdr(24'h012345, 8'd1);
    plan_word(32'hDEADBEEF);
    send_req(24'h012345, 8'd1, ok);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b want 1", busy);
    end
    wait_idle("single");
    checks++;
    if (words_seen - w0 != 1) begin
      errors++;
      $display("FAIL single_words: got %0d want 1", words_seen - w0);
    end
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: cs_n=%b busy=%b want 1 0", cs_n, busy);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit seen;
    int w0;
    int r0;
    w0 = words_seen;
    r0 = rises;
    plan_hdr(24'h100000, 8'd3);
    for (int i = 0; i < 3; i++) plan_word($urandom);
    word_ready = 1'b0;
    send_req(24'h100000, 8'd3, ok);
    for (int w = 0; w < 3; w++) begin
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (word_valid === 1'b1) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL stall_valid: word %0d never valid, want valid", w);
      end
      repeat (20) step();
      checks++;
      if (cs_n !== 1'b0 || word_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_state: cs_n=%b word_valid=%b after stall, want 0 1", cs_n, word_valid);
      end
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
    end
    checks++;
    if (rises != r0) begin
      errors++;
      $display("FAIL stall_cs: cs_n rose %0d times in burst, want 0", rises - r0);
    end
    word_ready = 1'b1;
    wait_idle("stall");
    checks++;
    if (words_seen - w0 != 3) begin
      errors++;
      $display("FAIL stall_words: got %0d want 3", words_seen - w0);
    end
  endtask

  task automatic test_len_zero();
    bit ok;
    int s0;
    int bad;
    s0 = starts;
    bad = 0;
    send_req(24'h00ABCD, 8'd0, ok);
    for (int i = 0; i < 20; i++) begin
      step();
      if (cs_n !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || starts != s0) begin
      errors++;
      $display("FAIL len_zero: bad_cycles=%0d starts=%0d, want 0 0", bad, starts - s0);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL len_zero_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    bit hit;
    int base;
    int w0;
    base = ndone;
    plan_hdr(24'hABCDEF, 8'd2);
    plan_word(32'h11223344);
    plan_word(32'h55667788);
    send_req(24'hABCDEF, 8'd2, ok);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ndone >= base + 3) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach: only %0d dones, want 3", ndone - base);
    end
    reset = 1'b1;
    step();
    checks++;
    if (cs_n !== 1'b1 || spi_start !== 1'b0 || word_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: cs_n=%b start=%b wv=%b busy=%b, want 1 0 0 0",
               cs_n, spi_start, word_valid, busy);
    end
    step();
    reset = 1'b0;
    step();
    w0 = words_seen;
    plan_hdr(24'h000010, 8'd1);
    plan_word(32'h13579BDF);
    send_req(24'h000010, 8'd1, ok);
    wait_idle("abort");
    checks++;
    if (words_seen - w0 != 1) begin
      errors++;
      $display("FAIL abort_words: got %0d want 1", words_seen - w0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int w0;
    w0 = words_seen;
    plan_hdr(24'h7FFFFC, 8'd2);
    plan_word(32'hCAFEF00D);
    plan_word(32'h0BADC0DE);
    send_req(24'h7FFFFC, 8'd2, ok);
    wait_idle("b2b_a");
    plan_hdr(24'hFFFFFF, 8'd1);
    plan_word(32'h80000001);
    send_req(24'hFFFFFF, 8'd1, ok);
    wait_idle("b2b_b");
    checks++;
    if (words_seen - w0 != 3) begin
      errors++;
      $display("FAIL b2b_words: got %0d want 3", words_seen - w0);
    end
  endtask

  task automatic test_addr_zero();
    bit ok;
    int w0;
    w0 = words_seen;
    plan_hdr(24'h000000, 8'd1);
    plan_word(32'h0F1E2D3C);
    send_req(24'h000000, 8'd1, ok);
    wait_idle("addr0");
    checks++;
    if (words_seen - w0 != 1) begin
      errors++;
      $display("FAIL addr0_words: got %0d want 1", words_seen - w0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_len_zero();
    test_reset_abort();
    test_back_to_back();
    test_addr_zero();
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

endmodule
